// File: rtl/gb_alu_exec.sv
// gb_alu_exec - execution stage behind the CPU register file.
//
// Takes operands from the register-file read ports and computes 8-bit or 16-bit
// ALU results. Results go back through the register-file write port. This block
// owns the F register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid / op_ready      operation handshake; an op is accepted on a rising
//                            edge where both are high
//   op_code, op_dst          operation select, destination register index
//   op_a, op_a_lo            operand A (high byte of first pair) and low byte
//   op_b, op_b_lo            operand B (high byte of second pair) and low byte
//   f_we, f_wdata            direct load of F (POP AF); low nibble is ignored
//   wb_write_flag            0 none, 1 byte write, 2 pair write (hi to wb_reg,
//                            lo to wb_reg+1)
//   wb_reg, wb_data          write target and data
//   flags_out                F register {Z,N,H,C,4'b0}
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready; 8-bit ops complete here, 16-bit ops latch their low byte
// HI    | 16-bit op in flight; high byte computed and written back
module gb_alu_exec #(
    parameter int NUM_REGS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [4:0]  op_code,
    input  logic [3:0]  op_dst,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_a_lo,
    input  logic [7:0]  op_b,
    input  logic [7:0]  op_b_lo,
    input  logic        f_we,
    input  logic [7:0]  f_wdata,
    output logic [1:0]  wb_write_flag,
    output logic [3:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic [7:0]  flags_out
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADC   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SBC   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_CP    = 5'd7;
    localparam logic [4:0] OP_INC8  = 5'd8;
    localparam logic [4:0] OP_DEC8  = 5'd9;
    localparam logic [4:0] OP_INC16 = 5'd10;
    localparam logic [4:0] OP_DEC16 = 5'd11;
    localparam logic [4:0] OP_ADD16 = 5'd12;
    localparam logic [4:0] OP_SWAP  = 5'd13;
    localparam logic [4:0] OP_CPL   = 5'd14;
    localparam logic [4:0] OP_SCF   = 5'd15;
    localparam logic [4:0] OP_CCF   = 5'd16;

    typedef enum logic {IDLE, HI} state_t;

    state_t      state;
    logic [3:0]  flags;          // {Z,N,H,C}
    logic [4:0]  hiOp;
    logic [3:0]  hiDst;
    logic [7:0]  hiA;
    logic [7:0]  hiB;
    logic [7:0]  loRes;
    logic        loCarry;        // carry (INC16/ADD16) or borrow (DEC16) from the low byte
    logic [1:0]  wbFlag;
    logic [3:0]  wbReg;
    logic [15:0] wbData;

    // 8-bit datapath and 16-bit low-byte step, evaluated in IDLE.
    logic        cin;
    logic [8:0]  sum9;
    logic [4:0]  half5;
    logic [7:0]  res8;
    logic [3:0]  flags8;
    logic        wr8;
    logic        is16;
    logic [8:0]  lo9;

    always_comb begin
        cin    = 1'b0;
        sum9   = '0;
        half5  = '0;
        res8   = '0;
        flags8 = flags;
        wr8    = 1'b0;
        is16   = 1'b0;
        lo9    = '0;
        case (op_code)
            OP_ADD, OP_ADC: begin
                cin    = (op_code == OP_ADC) & flags[0];
                sum9   = {1'b0, op_a} + {1'b0, op_b} + {8'b0, cin};
                half5  = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'b0, cin};
                res8   = sum9[7:0];
                flags8 = {(res8 == 8'h00), 1'b0, half5[4], sum9[8]};
                wr8    = 1'b1;
            end
            OP_SUB, OP_SBC, OP_CP: begin
                // Wrapping subtraction: bit 8 / bit 4 go high exactly on a borrow.
                cin    = (op_code == OP_SBC) & flags[0];
                sum9   = {1'b0, op_a} - {1'b0, op_b} - {8'b0, cin};
                half5  = {1'b0, op_a[3:0]} - {1'b0, op_b[3:0]} - {4'b0, cin};
                res8   = sum9[7:0];
                flags8 = {(res8 == 8'h00), 1'b1, half5[4], sum9[8]};
                wr8    = (op_code != OP_CP);
            end
            OP_AND: begin
                res8   = op_a & op_b;
                flags8 = {(res8 == 8'h00), 1'b0, 1'b1, 1'b0};
                wr8    = 1'b1;
            end
            OP_XOR: begin
                res8   = op_a ^ op_b;
                flags8 = {(res8 == 8'h00), 3'b000};
                wr8    = 1'b1;
            end
            OP_OR: begin
                res8   = op_a | op_b;
                flags8 = {(res8 == 8'h00), 3'b000};
                wr8    = 1'b1;
            end
            OP_INC8: begin
                res8   = op_a + 8'd1;
                flags8 = {(res8 == 8'h00), 1'b0, (op_a[3:0] == 4'hF), flags[0]};
                wr8    = 1'b1;
            end
            OP_DEC8: begin
                res8   = op_a - 8'd1;
                flags8 = {(res8 == 8'h00), 1'b1, (op_a[3:0] == 4'h0), flags[0]};
                wr8    = 1'b1;
            end
            OP_SWAP: begin
                res8   = {op_a[3:0], op_a[7:4]};
                flags8 = {(res8 == 8'h00), 3'b000};
                wr8    = 1'b1;
            end
            OP_CPL: begin
                res8   = ~op_a;
                flags8 = {flags[3], 1'b1, 1'b1, flags[0]};
                wr8    = 1'b1;
            end
            OP_SCF: flags8 = {flags[3], 1'b0, 1'b0, 1'b1};
            OP_CCF: flags8 = {flags[3], 1'b0, 1'b0, ~flags[0]};
            OP_INC16: begin
                is16 = 1'b1;
                lo9  = {1'b0, op_a_lo} + 9'd1;
            end
            OP_DEC16: begin
                is16 = 1'b1;
                lo9  = {1'b0, op_a_lo} - 9'd1;
            end
            OP_ADD16: begin
                is16 = 1'b1;
                lo9  = {1'b0, op_a_lo} + {1'b0, op_b_lo};
            end
            default: ;
        endcase
    end

    // High-byte step of a 16-bit op, evaluated in HI from latched operands.
    logic [8:0] hiSum9;
    logic [4:0] hiHalf5;
    logic [3:0] flags16;

    always_comb begin
        hiSum9  = '0;
        hiHalf5 = '0;
        flags16 = flags;
        case (hiOp)
            OP_INC16: hiSum9 = {1'b0, hiA} + {8'b0, loCarry};
            OP_DEC16: hiSum9 = {1'b0, hiA} - {8'b0, loCarry};
            default: begin
                // ADD16: H is the carry out of bit 11, i.e. bit 3 of the high byte.
                hiSum9  = {1'b0, hiA} + {1'b0, hiB} + {8'b0, loCarry};
                hiHalf5 = {1'b0, hiA[3:0]} + {1'b0, hiB[3:0]} + {4'b0, loCarry};
                flags16 = {flags[3], 1'b0, hiHalf5[4], hiSum9[8]};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            flags   <= '0;
            wbFlag  <= '0;
            wbReg   <= '0;
            wbData  <= '0;
            hiOp    <= '0;
            hiDst   <= '0;
            hiA     <= '0;
            hiB     <= '0;
            loRes   <= '0;
            loCarry <= 1'b0;
        end else begin
            wbFlag <= 2'd0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (is16) begin
                            hiOp    <= op_code;
                            hiDst   <= op_dst;
                            hiA     <= op_a;
                            hiB     <= op_b;
                            loRes   <= lo9[7:0];
                            loCarry <= lo9[8];
                            state   <= HI;
                        end else begin
                            flags <= flags8;
                            if (wr8) begin
                                wbFlag <= 2'd1;
                                wbReg  <= op_dst;
                                wbData <= {8'h00, res8};
                            end
                        end
                    end
                end
                HI: begin
                    wbFlag <= 2'd2;
                    wbReg  <= hiDst;
                    wbData <= {hiSum9[7:0], loRes};
                    flags  <= flags16;
                    state  <= IDLE;
                end
            endcase
            // A direct F load overrides any ALU flag update on the same edge.
            if (f_we) flags <= f_wdata[7:4];
        end
    end

    // An out-of-range destination is the controller's fault; the write still goes out.
    logic dstOk;
    always_comb begin
        dstOk = is16 ? ((int'(op_dst) + 1) < NUM_REGS) : (int'(op_dst) < NUM_REGS);
    end

    assert property (@(posedge clk) disable iff (rst)
        (op_valid && op_ready && (wr8 || is16)) |-> dstOk);

    logic unusedFwLo;
    assign unusedFwLo = ^f_wdata[3:0];

    assign op_ready      = (state == IDLE);
    assign wb_write_flag = wbFlag;
    assign wb_reg        = wbReg;
    assign wb_data       = wbData;
    assign flags_out     = {flags, 4'h0};

endmodule

// File: tb/tb_gb_alu_exec.sv
// tb_gb_alu_exec - directed self-checking bench for gb_alu_exec.
// Expected writebacks are queued when an op is driven and popped when the
// result should appear; inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_gb_alu_exec;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADC   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SBC   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_CP    = 5'd7;
    localparam logic [4:0] OP_INC8  = 5'd8;
    localparam logic [4:0] OP_DEC8  = 5'd9;
    localparam logic [4:0] OP_INC16 = 5'd10;
    localparam logic [4:0] OP_DEC16 = 5'd11;
    localparam logic [4:0] OP_ADD16 = 5'd12;
    localparam logic [4:0] OP_SWAP  = 5'd13;
    localparam logic [4:0] OP_CPL   = 5'd14;
    localparam logic [4:0] OP_SCF   = 5'd15;
    localparam logic [4:0] OP_CCF   = 5'd16;
    localparam logic [4:0] OP_NOP   = 5'd20;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op_code;
    logic [3:0]  op_dst;
    logic [7:0]  op_a;
    logic [7:0]  op_a_lo;
    logic [7:0]  op_b;
    logic [7:0]  op_b_lo;
    logic        f_we;
    logic [7:0]  f_wdata;
    logic [1:0]  wb_write_flag;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic [7:0]  flags_out;

    gb_alu_exec #(.NUM_REGS(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_code       (op_code),
        .op_dst        (op_dst),
        .op_a          (op_a),
        .op_a_lo       (op_a_lo),
        .op_b          (op_b),
        .op_b_lo       (op_b_lo),
        .f_we          (f_we),
        .f_wdata       (f_wdata),
        .wb_write_flag (wb_write_flag),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .flags_out     (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  fl;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [7:0]  f;
    } exp_t;

    exp_t sb[$];
    int   nAssert = 0;
    int   nFail   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expectWb(input logic [1:0] fl, input logic [3:0] rg,
                            input logic [15:0] data, input logic [7:0] f);
        exp_t e;
        e.fl = fl; e.rg = rg; e.data = data; e.f = f;
        sb.push_back(e);
    endtask

    task automatic checkWb(input string tag);
        exp_t e;
        nAssert++;
        assert (sb.size() > 0) else begin
            nFail++;
            $error("FAIL %s: scoreboard empty, observed flag %0d", tag, wb_write_flag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_flag"}, 16'(wb_write_flag), 16'(e.fl));
            if (e.fl != 2'd0) begin
                check({tag, "_reg"}, 16'(wb_reg), 16'(e.rg));
                check({tag, "_data"}, wb_data, e.data);
            end
            check({tag, "_F"}, 16'(flags_out), 16'(e.f));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents an op and returns on the falling edge after the accept edge;
    // op_valid is left high so consecutive calls issue back-to-back.
    task automatic drive(input logic [4:0] code, input logic [3:0] dst,
                         input logic [7:0] a, input logic [7:0] alo,
                         input logic [7:0] b, input logic [7:0] blo);
        op_valid = 1'b1;
        op_code  = code;
        op_dst   = dst;
        op_a     = a;
        op_a_lo  = alo;
        op_b     = b;
        op_b_lo  = blo;
        tick();
    endtask

    task automatic loadF(input logic [7:0] v);
        op_valid = 1'b0;
        f_we     = 1'b1;
        f_wdata  = v;
        tick();
        f_we     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = '0; op_dst = '0;
        op_a = '0; op_a_lo = '0; op_b = '0; op_b_lo = '0;
        f_we = 1'b0; f_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 16'(op_ready), 16'd1);
        check("rst_wbflag", 16'(wb_write_flag), 16'd0);
        check("rst_wbreg", 16'(wb_reg), 16'd0);
        check("rst_wbdata", wb_data, 16'h0000);
        check("rst_F", 16'(flags_out), 16'h00);

        expectWb(2'd1, 4'd0, 16'h0000, 8'hB0);
        drive(OP_ADD, 4'd0, 8'h3A, 8'h00, 8'hC6, 8'h00);
        op_valid = 1'b0;
        checkWb("add");
        check("add_ready", 16'(op_ready), 16'd1);
        tick();
        check("add_pulse_one_cycle", 16'(wb_write_flag), 16'd0);

        loadF(8'h1F);
        check("fload_mask", 16'(flags_out), 16'h10);
        expectWb(2'd1, 4'd1, 16'h00F1, 8'h20);
        drive(OP_ADC, 4'd1, 8'hE1, 8'h00, 8'h0F, 8'h00);
        checkWb("adc");
        expectWb(2'd1, 4'd2, 16'h0000, 8'hC0);
        drive(OP_SUB, 4'd2, 8'h3E, 8'h00, 8'h3E, 8'h00);
        checkWb("sub");
        expectWb(2'd0, 4'd0, 16'h0000, 8'h50);
        drive(OP_CP, 4'd9, 8'h3C, 8'h00, 8'h40, 8'h00);
        op_valid = 1'b0;
        checkWb("cp");

        loadF(8'hB0);
        expectWb(2'd2, 4'd6, 16'h9028, 8'hA0);
        drive(OP_ADD16, 4'd6, 8'h8A, 8'h23, 8'h06, 8'h05);
        check("add16_ready_hi", 16'(op_ready), 16'd0);
        check("add16_nowb_k", 16'(wb_write_flag), 16'd0);
        op_code = OP_INC8; op_dst = 4'd3; op_a = 8'h41;
        tick();
        op_valid = 1'b0;
        checkWb("add16");
        check("add16_ready_back", 16'(op_ready), 16'd1);
        tick();
        check("add16_hi_op_ignored", 16'(wb_write_flag), 16'd0);
        check("add16_F_hold", 16'(flags_out), 16'hA0);

        loadF(8'h10);
        expectWb(2'd1, 4'd4, 16'h0000, 8'hB0);
        drive(OP_INC8, 4'd4, 8'hFF, 8'h00, 8'h00, 8'h00);
        op_valid = 1'b0;
        checkWb("inc8");
        expectWb(2'd2, 4'd7, 16'hFFFF, 8'hB0);
        drive(OP_DEC16, 4'd7, 8'h00, 8'h00, 8'h00, 8'h00);
        op_valid = 1'b0;
        tick();
        checkWb("dec16");
        expectWb(2'd2, 4'd8, 16'h0000, 8'hB0);
        drive(OP_INC16, 4'd8, 8'hFF, 8'hFF, 8'h00, 8'h00);
        op_valid = 1'b0;
        tick();
        checkWb("inc16");

        loadF(8'h00);
        expectWb(2'd1, 4'd0, 16'h0005, 8'h20);
        expectWb(2'd1, 4'd1, 16'h003C, 8'h00);
        expectWb(2'd1, 4'd2, 16'h0000, 8'h80);
        drive(OP_AND, 4'd0, 8'hF5, 8'h00, 8'h0F, 8'h00);
        checkWb("b2b_and");
        drive(OP_OR, 4'd1, 8'h30, 8'h00, 8'h0C, 8'h00);
        checkWb("b2b_or");
        drive(OP_XOR, 4'd2, 8'h5A, 8'h00, 8'h5A, 8'h00);
        checkWb("b2b_xor");
        op_valid = 1'b0;
        tick();
        check("b2b_end", 16'(wb_write_flag), 16'd0);

        loadF(8'h10);
        expectWb(2'd1, 4'd3, 16'h000E, 8'h60);
        drive(OP_SBC, 4'd3, 8'h10, 8'h00, 8'h01, 8'h00);
        checkWb("sbc");
        expectWb(2'd1, 4'd4, 16'h000F, 8'h60);
        drive(OP_DEC8, 4'd4, 8'h10, 8'h00, 8'h00, 8'h00);
        checkWb("dec8");
        expectWb(2'd1, 4'd5, 16'h000F, 8'h00);
        drive(OP_SWAP, 4'd5, 8'hF0, 8'h00, 8'h00, 8'h00);
        checkWb("swap");
        expectWb(2'd1, 4'd6, 16'h00CA, 8'h60);
        drive(OP_CPL, 4'd6, 8'h35, 8'h00, 8'h00, 8'h00);
        checkWb("cpl");
        expectWb(2'd0, 4'd0, 16'h0000, 8'h10);
        drive(OP_SCF, 4'd9, 8'h00, 8'h00, 8'h00, 8'h00);
        checkWb("scf");
        expectWb(2'd0, 4'd0, 16'h0000, 8'h10);
        drive(OP_NOP, 4'd9, 8'h12, 8'h00, 8'h34, 8'h00);
        checkWb("nop");
        expectWb(2'd0, 4'd0, 16'h0000, 8'h00);
        drive(OP_CCF, 4'd9, 8'h00, 8'h00, 8'h00, 8'h00);
        checkWb("ccf");
        op_valid = 1'b0;

        f_we = 1'b1; f_wdata = 8'hFF;
        expectWb(2'd1, 4'd5, 16'h0002, 8'hF0);
        drive(OP_ADD, 4'd5, 8'h01, 8'h00, 8'h01, 8'h00);
        f_we = 1'b0; op_valid = 1'b0;
        checkWb("fwe_wins");

        loadF(8'hB0);
        drive(OP_ADD16, 4'd6, 8'h8A, 8'h23, 8'h06, 8'h05);
        op_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstHI_wbflag", 16'(wb_write_flag), 16'd0);
        check("rstHI_F", 16'(flags_out), 16'h00);
        check("rstHI_ready", 16'(op_ready), 16'd1);
        check("rstHI_wbreg", 16'(wb_reg), 16'd0);
        check("rstHI_wbdata", wb_data, 16'h0000);
        tick();
        check("rstHI_discarded", 16'(wb_write_flag), 16'd0);

        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
